rs485_rx: RTL and testbench
===========================

# rs485_rx

Serial receiver on the RS-485 receive path, the counterpart of the transmit serializer. Recovers the frame format the transmitter emits: start bit (0), 8 data bits LSB first, even parity bit (XOR of data), stop bit (1), at 9600 baud. Delivers each received byte to the protocol logic through a valid/ack holding register. Reports parity, framing and overrun errors.

## Interface
- CLK_HZ, 25_000_000, system clock frequency
- BAUD, 9600, line bit rate
- BIT_CNT, CLK_HZ/BAUD (2604), clocks per bit; derived, not overridden
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- rx  input  1  RS-485 transceiver RO line, asynchronous, idle high
- rx_ack  input  1  consumer has taken rx_data; clears rx_vld
- rx_data  output  8  last received byte, held until next good frame
- rx_vld  output  1  rx_data is new and unacknowledged
- parity_err  output  1  parity status of the byte in rx_data, valid while rx_vld=1
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: good frame completed while rx_vld=1
- is_busy  output  1  high in every state except IDLE

## Operation
- rx passes through a 2-flop synchronizer reset to 1; all logic uses synchronized rx_s.
- Bit counter cnt, 12 bits, counts 0..BIT_CNT-1, cleared on every state entry.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on rx_s falling edge (previous 1, current 0) -> START.
- START: at cnt == BIT_CNT/2-1 (1301) sample rx_s; 0 -> DATA (bit index 0); 1 -> IDLE (glitch, nothing reported).
- DATA: at cnt == BIT_CNT-1 sample rx_s into shift register bit[idx]; idx 7 -> PARITY, else idx+1.
- PARITY: at cnt == BIT_CNT-1 sample parity bit -> STOP.
- STOP: at cnt == BIT_CNT-1 sample; 1 -> load rx_data, set rx_vld, set parity_err = (parity bit != ^data), -> IDLE. 0 -> pulse frame_err, rx_data/rx_vld unchanged, -> WAIT_IDLE.
- WAIT_IDLE: remain until rx_s == 1, then -> IDLE (line break does not retrigger).
- rx_vld clears on the cycle after rx_ack=1. rx_ack while rx_vld=0 ignored.
- Good frame completing while rx_vld=1: rx_data/parity_err overwritten, rx_vld stays 1, overrun pulses. Same cycle as rx_ack: new data wins, rx_vld stays 1, no overrun.

## Timing
- Reset values: rx_data=0x00, rx_vld=0, parity_err=0, frame_err=0, overrun=0, is_busy=0, state IDLE.
- Reset mid-frame: immediate return to reset values; partial byte discarded.
- Start detection latency: 3 clk after rx pin falls (2 sync + edge).
- Samples fall at bit centre: start at +1302 clk, data bit n at +1302+2604*(n+1).
- rx_vld, parity_err, rx_data registered; rise 1 clk after stop-bit sample, ~10.5 bit times (~27340 clk) after start edge.
- frame_err and overrun exactly one clk wide.
- Back-to-back frames: returning to IDLE at mid stop bit gives half a bit of margin for the next start edge.

## Configuration
- RS485_RX_PARITY_CHECK_EN defined: parity compared as above, parity_err driven.
- Undefined: parity bit still sampled (frame length unchanged) but not checked; parity_err tied 0.

## Structure
- rs485_pkg: state enum, BIT_CNT/HALF_CNT computation, frame length constant (shared with transmitter).
- Sub-module rs485_sync: 2-flop synchronizer, reset value parameterized (1 here).

## Test plan
- Frame 0xA5, parity 0, stop 1 -> rx_data=0xA5, rx_vld=1, parity_err=0, ~27340 clk after start edge; rx_ack -> rx_vld=0 next clk.
- Frame 0x01 with parity 0 -> rx_vld=1, rx_data=0x01, parity_err=1 (macro on); parity_err=0 (macro off).
- rx low for 500 clk then high -> back to IDLE, no rx_vld/frame_err, is_busy drops after sample at 1302.
- Frame 0x3C with stop bit 0, line held low 5 bit times -> frame_err single pulse, rx_vld=0, no new frame until line high then new edge.
- Frames 0x11 then 0x22 without rx_ack -> overrun pulse, rx_data=0x22, rx_vld=1; repeat with rx_ack coincident -> no overrun.
- rst asserted mid DATA of 0xFF -> all outputs reset; following clean 0x5A received correctly.

Source files
------------

// File: rtl/rs485_pkg.sv
// rs485_pkg: shared RS-485 serial constants, receiver state encoding and baud helpers.
package rs485_pkg;

  localparam int unsigned DEF_CLK_HZ = 25_000_000;
  localparam int unsigned DEF_BAUD   = 9600;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned IDX_W      = 3;
  // start + 8 data + parity + stop, identical on the transmit side
  localparam int unsigned FRAME_BITS = 11;

  // clocks per bit and the half-bit offset used to reach the bit centre
  function automatic int unsigned bit_cnt(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned half_cnt(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz / baud) / 2;
  endfunction

  localparam int unsigned BIT_CNT  = bit_cnt(DEF_CLK_HZ, DEF_BAUD);
  localparam int unsigned HALF_CNT = half_cnt(DEF_CLK_HZ, DEF_BAUD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/rs485_rx_if.sv
// rs485_rx_if: RS-485 receive line plus the byte valid/ack and error reporting bundle.
interface rs485_rx_if;
  import rs485_pkg::*;

  logic              rx;
  logic              rx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_vld;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              is_busy;

  // receiver side
  modport master (
    input  rx, rx_ack,
    output rx_data, rx_vld, parity_err, frame_err, overrun, is_busy
  );

  // line driver / byte consumer side
  modport slave (
    output rx, rx_ack,
    input  rx_data, rx_vld, parity_err, frame_err, overrun, is_busy
  );
endinterface

// File: rtl/rs485_sync.sv
// rs485_sync: two-flop synchronizer for an asynchronous input, reset value selectable.
module rs485_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs485_rx.sv
// rs485_rx: 8E1 serial receiver with valid/ack holding register and error reporting.
// Optional build macro RS485_RX_PARITY_CHECK_EN enables parity checking; without it
// the parity bit is still timed on the line but parity_err stays 0.
module rs485_rx
  import rs485_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int unsigned BAUD   = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  rs485_rx_if.master bus
);

  localparam int unsigned BIT_LEN  = bit_cnt(CLK_HZ, BAUD);
  localparam int unsigned HALF_LEN = half_cnt(CLK_HZ, BAUD);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              busy_q;
  logic              rx_s;
  logic              rx_prev;
  logic              bit_end;
`ifdef RS485_RX_PARITY_CHECK_EN
  logic              par_q, par_d;
`endif

  rs485_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  assign bit_end = (cnt_q == CNT_W'(BIT_LEN - 1));

  // state, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      rx_prev <= 1'b1;
`ifdef RS485_RX_PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != ST_IDLE);
      rx_prev <= rx_s;
`ifdef RS485_RX_PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

  // next-state and output-register logic; samples are taken at the bit centre
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = vld_q;
    perr_d  = perr_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef RS485_RX_PARITY_CHECK_EN
    par_d   = par_q;
`endif

    if (bus.rx_ack) vld_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_W'(HALF_LEN - 1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_W'(DATA_W - 1)) state_d = ST_PARITY;
          else                             idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
`ifdef RS485_RX_PARITY_CHECK_EN
          par_d   = rx_s;
`endif
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            vld_d   = 1'b1;
            ovr_d   = vld_q && !bus.rx_ack;
`ifdef RS485_RX_PARITY_CHECK_EN
            perr_d  = par_q ^ (^shift_q);
`else
            perr_d  = 1'b0;
`endif
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_vld     = vld_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.is_busy    = busy_q;

endmodule

// File: tb/tb_rs485_rx.sv
// tb_rs485_rx: directed frames against rs485_rx at a reduced clock rate (32 clk per bit).
module tb_rs485_rx;
  import rs485_pkg::*;

  localparam int unsigned TB_CLK_HZ = 307_200;
  localparam int unsigned TB_BAUD   = 9600;
  localparam int          BIT       = 32;
  localparam int          HALF      = BIT / 2;
  // fall -> sync (2) -> edge (1) -> start centre -> 10 more bit periods
  localparam int          LAT       = 3 + HALF + 10 * BIT;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   ferr_cnt;
  int   ovr_cnt;
  int   lat;

  rs485_rx_if bus_if ();

  rs485_rx #(.CLK_HZ(TB_CLK_HZ), .BAUD(TB_BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters: a two-cycle pulse would count twice
  always @(negedge clk) begin
    if (rst) begin
      if (bus_if.frame_err === 1'b1) ferr_cnt++;
      if (bus_if.overrun === 1'b1)   ovr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drive the first nbits of a frame, one bit per BIT clocks, starting at a negedge
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits);
    logic [FRAME_BITS-1:0] fr;
    fr = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus_if.rx = fr[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic do_ack();
    bus_if.rx_ack = 1'b1;
    @(negedge clk);
    bus_if.rx_ack = 1'b0;
    check("ack_clears_vld", 32'(bus_if.rx_vld), 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    ferr_cnt = 0;
    ovr_cnt  = 0;
    rst           = 1'b0;
    bus_if.rx     = 1'b1;
    bus_if.rx_ack = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_data", 32'(bus_if.rx_data), 32'h00);
    check("rst_vld", 32'(bus_if.rx_vld), 32'd0);
    check("rst_perr", 32'(bus_if.parity_err), 32'd0);
    check("rst_ferr", 32'(bus_if.frame_err), 32'd0);
    check("rst_ovr", 32'(bus_if.overrun), 32'd0);
    check("rst_busy", 32'(bus_if.is_busy), 32'd0);

    rst = 1'b1;
    repeat (BIT) @(negedge clk);

    // 0xA5, correct parity, with latency measurement
    lat = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, FRAME_BITS);
      begin
        while (bus_if.rx_vld !== 1'b1 && lat < 1000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("a5_latency", 32'(lat), 32'(LAT));
    check("a5_data", 32'(bus_if.rx_data), 32'hA5);
    check("a5_vld", 32'(bus_if.rx_vld), 32'd1);
    check("a5_perr", 32'(bus_if.parity_err), 32'd0);
    do_ack();
    repeat (BIT) @(negedge clk);

    // 0x01 with wrong parity bit
    send_frame(8'h01, 1'b0, 1'b1, FRAME_BITS);
    check("p01_data", 32'(bus_if.rx_data), 32'h01);
    check("p01_vld", 32'(bus_if.rx_vld), 32'd1);
`ifdef RS485_RX_PARITY_CHECK_EN
    check("p01_perr", 32'(bus_if.parity_err), 32'd1);
`else
    check("p01_perr", 32'(bus_if.parity_err), 32'd0);
`endif
    do_ack();
    repeat (BIT) @(negedge clk);

    // short glitch shorter than half a bit
    bus_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", 32'(bus_if.is_busy), 32'd1);
    repeat (4) @(negedge clk);
    bus_if.rx = 1'b1;
    repeat (HALF + 4) @(negedge clk);
    check("glitch_idle", 32'(bus_if.is_busy), 32'd0);
    check("glitch_vld", 32'(bus_if.rx_vld), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt), 32'd0);
    repeat (BIT) @(negedge clk);

    // 0x3C with stop bit 0, line held low five bit times
    send_frame(8'h3C, 1'b0, 1'b0, FRAME_BITS);
    check("ferr_pulse", 32'(ferr_cnt), 32'd1);
    check("ferr_vld", 32'(bus_if.rx_vld), 32'd0);
    check("ferr_busy", 32'(bus_if.is_busy), 32'd1);
    repeat (4 * BIT) @(negedge clk);
    check("ferr_no_retrig", 32'(ferr_cnt), 32'd1);
    check("ferr_wait_busy", 32'(bus_if.is_busy), 32'd1);
    bus_if.rx = 1'b1;
    repeat (4) @(negedge clk);
    check("ferr_idle", 32'(bus_if.is_busy), 32'd0);
    check("ferr_data_kept", 32'(bus_if.rx_data), 32'h01);
    repeat (BIT) @(negedge clk);

    // back-to-back 0x11, 0x22 without ack
    send_frame(8'h11, 1'b0, 1'b1, FRAME_BITS);
    check("b2b_first", 32'(bus_if.rx_data), 32'h11);
    check("b2b_no_ovr", 32'(ovr_cnt), 32'd0);
    send_frame(8'h22, 1'b0, 1'b1, FRAME_BITS);
    check("ovr_pulse", 32'(ovr_cnt), 32'd1);
    check("ovr_data", 32'(bus_if.rx_data), 32'h22);
    check("ovr_vld", 32'(bus_if.rx_vld), 32'd1);

    // 0x33 with ack landing in the stop-sample cycle
    fork
      send_frame(8'h33, 1'b0, 1'b1, FRAME_BITS);
      begin
        repeat (LAT - 1) @(negedge clk);
        bus_if.rx_ack = 1'b1;
        @(negedge clk);
        bus_if.rx_ack = 1'b0;
      end
    join
    check("coinc_no_ovr", 32'(ovr_cnt), 32'd1);
    check("coinc_data", 32'(bus_if.rx_data), 32'h33);
    check("coinc_vld", 32'(bus_if.rx_vld), 32'd1);

    // reset in the middle of 0xFF data bits
    send_frame(8'hFF, 1'b0, 1'b1, 4);
    check("mid_busy", 32'(bus_if.is_busy), 32'd1);
    rst       = 1'b0;
    bus_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_data", 32'(bus_if.rx_data), 32'h00);
    check("mrst_vld", 32'(bus_if.rx_vld), 32'd0);
    check("mrst_perr", 32'(bus_if.parity_err), 32'd0);
    check("mrst_busy", 32'(bus_if.is_busy), 32'd0);
    rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("mrst_stay_idle", 32'(bus_if.is_busy), 32'd0);

    send_frame(8'h5A, 1'b0, 1'b1, FRAME_BITS);
    check("post_data", 32'(bus_if.rx_data), 32'h5A);
    check("post_vld", 32'(bus_if.rx_vld), 32'd1);
    check("post_perr", 32'(bus_if.parity_err), 32'd0);
    check("post_ferr", 32'(ferr_cnt), 32'd1);
    check("post_ovr", 32'(ovr_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
